fperm_wb_buf: RTL

FPERM_WB_BUF -- requirements
Module: fperm_wb_buf

---
 rtl/fperm_wb_buf.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fperm_wb_buf.sv
// Permute-stage writeback buffer.
// Tracks destination tags alongside the fixed-latency permute pipe, captures
// results into an in-order FIFO, and hands out issue credit so a capture can
// never find the FIFO full.
// Optional feature: define FPERM_WB_BYPASS_EN to let a result go straight to
// writeback in its capture cycle when the FIFO is empty.
module fperm_wb_buf #(
    parameter int LAT   = 1,
    parameter int DEPTH = 4,
    parameter int TAG_W = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_en,
    input  logic [TAG_W-1:0]         issue_tag,
    output logic                     issue_rdy,
    input  logic [67:0]              res_in,
    input  logic                     flush,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [67:0]              wb_data,
    output logic [1:0]               wb_type,
    output logic [TAG_W-1:0]         wb_tag,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

    logic [LAT-1:0]   pv;
    logic [TAG_W-1:0] pt [LAT];
    logic [67:0]      mem  [DEPTH];
    logic [TAG_W-1:0] tmem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    logic             issue_ok;
    logic             out_vld;
    logic [TAG_W-1:0] out_tag;
    logic             cap;
    logic             fifo_vld;
    logic             push;
    logic             pop;
    logic [1:0]       inflight;
    logic [CW:0]      occ;

    assign out_vld  = pv[LAT-1];
    assign out_tag  = pt[LAT-1];
    assign cap      = out_vld & ~flush;
    assign fifo_vld = (count != '0) & ~flush & ~rst;
    assign pop      = fifo_vld & wb_ready;
    assign issue_ok = issue_en & issue_rdy & ~flush;
    assign wb_type  = wb_data[67:66];

    // Credit: buffered plus in-flight results must fit in the FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + {1'b0, pv[i]};
        end
        occ       = {1'b0, count} + {{(CW-1){1'b0}}, inflight};
        issue_rdy = ~rst & (occ < DEPTH_V);
    end

`ifdef FPERM_WB_BYPASS_EN
    logic byp;
    assign byp      = (count == '0) & out_vld & ~flush & ~rst;
    // A bypassed result that is accepted immediately never enters the FIFO.
    assign push     = cap & ~(byp & wb_ready);
    assign wb_valid = fifo_vld | byp;
    assign wb_data  = fifo_vld ? mem[rd_ptr]  : res_in;
    assign wb_tag   = fifo_vld ? tmem[rd_ptr] : out_tag;
`else
    assign push     = cap;
    assign wb_valid = fifo_vld;
    assign wb_data  = mem[rd_ptr];
    assign wb_tag   = tmem[rd_ptr];
`endif

    // Control state: tag-pipe valids, FIFO pointers/occupancy, sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            pv      <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else if (flush) begin
            pv      <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            pv[0] <= issue_ok;
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (issue_en && !issue_rdy) ovf_err <= 1'b1;
        end
    end

    // Datapath: tag shift and FIFO storage; res_in is sampled only on a push.
    always_ff @(posedge clk) begin
        pt[0] <= issue_tag;
        for (int i = 1; i < LAT; i++) begin
            pt[i] <= pt[i-1];
        end
        if (push) begin
            mem[wr_ptr]  <= res_in;
            tmem[wr_ptr] <= out_tag;
        end
    end

endmodule
